// File: rtl/controle_iluminacao.sv
// rtl/controle_iluminacao.sv - lamp controller with manual/automatic modes and presence hold-off
module controle_iluminacao #(
    parameter int AUTO_SHUTDOWN_T = 30000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic infravermelho,
    output logic L,
    output logic M
);

    typedef enum logic [1:0] {
        MAN_OFF  = 2'b00,
        MAN_ON   = 2'b01,
        AUTO_OFF = 2'b10,
        AUTO_ON  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(AUTO_SHUTDOWN_T);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             A_d;
    logic             B_d;
    logic             armed;
    logic             long_ev;
    logic             short_ev;

    // armed stays low for the first edge after reset so that A_d/B_d can pick up
    // levels held through reset before any edge is decoded from them
    assign long_ev  = armed & A & ~A_d;
    assign short_ev = armed & ~B & B_d & ~A;

    // State, counter and press-history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MAN_OFF;
            cnt   <= '0;
            A_d   <= 1'b0;
            B_d   <= 1'b0;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            A_d   <= A;
            B_d   <= B;
            armed <= 1'b1;
        end
    end

    // Next-state and shutdown counter update
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            MAN_OFF, MAN_ON: begin
                if (long_ev) begin
                    if (infravermelho) begin
                        state_next = AUTO_ON;
                        cnt_next   = RELOAD;
                    end else begin
                        state_next = AUTO_OFF;
                        cnt_next   = '0;
                    end
                end else if (short_ev) begin
                    state_next = (state == MAN_OFF) ? MAN_ON : MAN_OFF;
                end
            end
            AUTO_OFF: begin
                if (long_ev) begin
                    state_next = MAN_OFF;
                    cnt_next   = '0;
                end else if (infravermelho) begin
                    state_next = AUTO_ON;
                    cnt_next   = RELOAD;
                end
            end
            AUTO_ON: begin
                if (long_ev) begin
                    state_next = MAN_OFF;
                    cnt_next   = '0;
                end else if (infravermelho) begin
                    cnt_next = RELOAD;
                end else if (cnt <= ONE) begin
                    state_next = AUTO_OFF;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - ONE;
                end
            end
            default: begin
                state_next = MAN_OFF;
                cnt_next   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state register only
    always_comb begin
        L = (state == MAN_ON) || (state == AUTO_ON);
        M = (state == AUTO_OFF) || (state == AUTO_ON);
    end

endmodule

// File: tb/tb_controle_iluminacao.sv
// tb/tb_controle_iluminacao.sv - scoreboard bench for controle_iluminacao
module tb_controle_iluminacao;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic ir;
    logic l;
    logic m;

    typedef struct packed {
        logic       r;
        logic       a;
        logic       b;
        logic       ir;
        logic [1:0] lm;
    } vec_t;

    vec_t       vq[$];
    logic [1:0] exp_q[$];
    int         vectors;
    int         miscompares;

    controle_iluminacao #(
        .AUTO_SHUTDOWN_T(10),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .A(a),
        .B(b),
        .infravermelho(ir),
        .L(l),
        .M(m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // append n identical cycles: inputs and the {L,M} expected after that edge
    task automatic add(input logic r_i, input logic a_i, input logic b_i, input logic ir_i,
                       input logic [1:0] lm_i, input int n);
        vec_t v;
        v.r  = r_i;
        v.a  = a_i;
        v.b  = b_i;
        v.ir = ir_i;
        v.lm = lm_i;
        repeat (n) vq.push_back(v);
    endtask

    // drive one queued vector, scoreboard its expectation, advance past the edge
    task automatic drive_one();
        vec_t v;
        v   = vq.pop_front();
        rst = v.r;
        a   = v.a;
        b   = v.b;
        ir  = v.ir;
        exp_q.push_back(v.lm);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] e;
        int i;
        add(1, 0, 0, 0, 2'b00, 3);
        add(0, 0, 0, 0, 2'b00, 2);
        i = 0;
        while (vq.size() > 0) begin
            drive_one();
            e = exp_q.pop_front();
            vectors++;
            if ({l, m} !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: L,M=%b required %b", i, {l, m}, e);
            end
            i++;
        end
    endtask

    task automatic test_manual_short();
        logic [1:0] e;
        int i;
        add(0, 0, 1, 0, 2'b00, 5);
        add(0, 0, 0, 0, 2'b10, 3);
        add(0, 0, 1, 0, 2'b10, 5);
        add(0, 0, 0, 0, 2'b00, 3);
        i = 0;
        while (vq.size() > 0) begin
            drive_one();
            e = exp_q.pop_front();
            vectors++;
            if ({l, m} !== e) begin
                miscompares++;
                $display("FAIL manual_short[%0d]: L,M=%b required %b", i, {l, m}, e);
            end
            i++;
        end
    endtask

    task automatic test_mode_switch();
        logic [1:0] e;
        int i;
        add(0, 0, 1, 0, 2'b00, 4);
        add(0, 1, 0, 0, 2'b01, 6);
        add(0, 0, 0, 0, 2'b01, 2);
        add(0, 0, 1, 0, 2'b01, 4);
        add(0, 1, 0, 0, 2'b00, 6);
        add(0, 0, 0, 0, 2'b00, 2);
        i = 0;
        while (vq.size() > 0) begin
            drive_one();
            e = exp_q.pop_front();
            vectors++;
            if ({l, m} !== e) begin
                miscompares++;
                $display("FAIL mode_switch[%0d]: L,M=%b required %b", i, {l, m}, e);
            end
            i++;
        end
    endtask

    task automatic test_auto_holdoff();
        logic [1:0] e;
        int i;
        add(0, 1, 0, 0, 2'b01, 1);
        add(0, 0, 0, 0, 2'b01, 1);
        add(0, 0, 0, 1, 2'b11, 3);
        add(0, 0, 0, 0, 2'b11, 9);
        add(0, 0, 0, 0, 2'b01, 2);
        add(0, 0, 0, 1, 2'b11, 3);
        add(0, 0, 0, 0, 2'b11, 6);
        add(0, 0, 0, 1, 2'b11, 1);
        add(0, 0, 0, 0, 2'b11, 9);
        add(0, 0, 0, 0, 2'b01, 2);
        i = 0;
        while (vq.size() > 0) begin
            drive_one();
            e = exp_q.pop_front();
            vectors++;
            if ({l, m} !== e) begin
                miscompares++;
                $display("FAIL auto_holdoff[%0d]: L,M=%b required %b", i, {l, m}, e);
            end
            i++;
        end
    endtask

    task automatic test_auto_immunity_exit();
        logic [1:0] e;
        int i;
        add(0, 0, 0, 1, 2'b11, 2);
        add(0, 0, 0, 0, 2'b11, 3);
        add(0, 0, 1, 0, 2'b11, 2);
        add(0, 0, 0, 0, 2'b11, 1);
        add(0, 1, 0, 0, 2'b00, 3);
        add(0, 0, 0, 0, 2'b00, 1);
        add(0, 1, 0, 0, 2'b01, 1);
        add(0, 0, 0, 0, 2'b01, 3);
        i = 0;
        while (vq.size() > 0) begin
            drive_one();
            e = exp_q.pop_front();
            vectors++;
            if ({l, m} !== e) begin
                miscompares++;
                $display("FAIL auto_immunity_exit[%0d]: L,M=%b required %b", i, {l, m}, e);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid_countdown();
        logic [1:0] e;
        int i;
        add(0, 0, 0, 1, 2'b11, 1);
        add(0, 0, 0, 0, 2'b11, 4);
        add(1, 1, 0, 0, 2'b00, 1);
        add(0, 1, 0, 0, 2'b00, 3);
        add(0, 0, 0, 0, 2'b00, 2);
        i = 0;
        while (vq.size() > 0) begin
            drive_one();
            e = exp_q.pop_front();
            vectors++;
            if ({l, m} !== e) begin
                miscompares++;
                $display("FAIL reset_mid_countdown[%0d]: L,M=%b required %b", i, {l, m}, e);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] e;
        int i;
        add(0, 0, 1, 0, 2'b00, 1);
        add(0, 0, 0, 0, 2'b10, 1);
        add(0, 0, 1, 0, 2'b10, 1);
        add(0, 0, 0, 0, 2'b00, 1);
        add(0, 1, 1, 0, 2'b01, 1);
        add(0, 0, 0, 0, 2'b01, 2);
        add(0, 1, 0, 0, 2'b00, 1);
        add(0, 0, 0, 0, 2'b00, 1);
        add(0, 1, 0, 1, 2'b11, 1);
        add(0, 0, 0, 0, 2'b11, 2);
        add(0, 1, 0, 0, 2'b00, 1);
        add(0, 0, 0, 0, 2'b00, 2);
        i = 0;
        while (vq.size() > 0) begin
            drive_one();
            e = exp_q.pop_front();
            vectors++;
            if ({l, m} !== e) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: L,M=%b required %b", i, {l, m}, e);
            end
            i++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        ir  = 1'b0;
        test_reset();
        test_manual_short();
        test_mode_switch();
        test_auto_holdoff();
        test_auto_immunity_exit();
        test_reset_mid_countdown();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
